golden_nonce_collector: RTL

- Gathers golden-ticket hits from NUM_HASHERS hasher channels into one serial transmit stream.
- Applies each channel's pipeline offset correction to the reported nonce.
- Arbitrates between simultaneous hits and buffers them in a FIFO, so hits arriving while the transmitter is busy are not lost.
- Sits between the hasher array and serial_transmit, replacing the single-channel golden_nonce/serial_send logic in the top level.

---
 rtl/golden_nonce_collector.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/golden_nonce_collector.sv
`default_nettype none
// ============================================================================
// Module      : golden_nonce_collector
// Description : Collects golden-ticket hits from NUM_HASHERS hasher channels,
//               corrects each nonce for the hasher pipeline offset, arbitrates
//               round-robin into a FIFO and feeds serial_transmit one word at
//               a time.
// Ports       : hash_clk       - sole clock
//               reset_in       - asynchronous active-low reset
//               hit_valid      - per-channel one-cycle hit strobe
//               hit_nonce      - raw nonce of channel i in [32i+31:32i]
//               serial_busy    - transmitter busy
//               clear_overflow - synchronous clear of overflow_count
//               serial_send    - one-cycle send pulse to the transmitter
//               golden_nonce   - corrected nonce, held from send until next pop
//               fifo_count     - FIFO occupancy
//               overflow_count - saturating count of dropped hits
// Revision    : 1.0 - initial release
// ============================================================================
module golden_nonce_collector #(
  parameter int          NUM_HASHERS         = 4,
  parameter logic [31:0] GOLDEN_NONCE_OFFSET = 32'd23,
  parameter int          FIFO_DEPTH          = 8,
  parameter int          OVF_W               = 16,
  parameter int          ACK_TIMEOUT         = 64
) (
  input  logic                        hash_clk,
  input  logic                        reset_in,
  input  logic [NUM_HASHERS-1:0]      hit_valid,
  input  logic [32*NUM_HASHERS-1:0]   hit_nonce,
  input  logic                        serial_busy,
  input  logic                        clear_overflow,
  output logic                        serial_send,
  output logic [31:0]                 golden_nonce,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [OVF_W-1:0]            overflow_count
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_PW = (NUM_HASHERS > 1) ? $clog2(NUM_HASHERS) : 1;
  localparam int c_TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int c_DW = $clog2(NUM_HASHERS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SENT = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_pop;
  logic [c_TW-1:0]        r_to_cnt;

  logic [NUM_HASHERS-1:0] w_pend_vld;
  logic [31:0]            w_pend_nonce [NUM_HASHERS];
  logic [NUM_HASHERS-1:0] w_grant;
  logic [NUM_HASHERS-1:0] w_drop;
  logic                   w_grant_any;
  logic [c_PW-1:0]        w_grant_idx;
  logic [c_PW-1:0]        r_rr_ptr;

  logic [31:0]            r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]        r_wr_ptr;
  logic [c_AW-1:0]        r_rd_ptr;
  logic                   w_full;
  logic [c_DW-1:0]        w_drop_cnt;
  logic [OVF_W:0]         w_ovf_sum;

  // Per-channel pending slot. A granted slot may be refilled by a hit in the
  // same cycle, so back-to-back hits on one channel stream at full rate.
  for (genvar i = 0; i < NUM_HASHERS; i++) begin : g_chan
    logic        r_vld;
    logic [31:0] r_nonce;

    always_ff @(posedge hash_clk or negedge reset_in) begin
      if (!reset_in) begin
        r_vld   <= 1'b0;
        r_nonce <= '0;
      end else if (hit_valid[i] && (!r_vld || w_grant[i])) begin
        r_vld   <= 1'b1;
        r_nonce <= hit_nonce[32*i +: 32] - GOLDEN_NONCE_OFFSET;
      end else if (w_grant[i]) begin
        r_vld   <= 1'b0;
      end
    end

    assign w_pend_vld[i]   = r_vld;
    assign w_pend_nonce[i] = r_nonce;
    assign w_drop[i]       = hit_valid[i] & r_vld & ~w_grant[i];
  end

  assign w_full     = (fifo_count == c_CW'(FIFO_DEPTH));
  assign w_drop_cnt = c_DW'($countones(w_drop));
  assign w_ovf_sum  = {1'b0, overflow_count} + (OVF_W+1)'(w_drop_cnt);

  // Round-robin: r_rr_ptr is the first channel searched, i.e. the one after
  // the last grant (channel 0 out of reset).
  always_comb begin
    int v_idx;
    v_idx       = 0;
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    if (!w_full) begin
      for (int j = 0; j < NUM_HASHERS; j++) begin
        v_idx = int'(r_rr_ptr) + j;
        if (v_idx >= NUM_HASHERS) v_idx = v_idx - NUM_HASHERS;
        if (!w_grant_any && w_pend_vld[c_PW'(v_idx)]) begin
          w_grant[c_PW'(v_idx)] = 1'b1;
          w_grant_any           = 1'b1;
          w_grant_idx           = c_PW'(v_idx);
        end
      end
    end
  end

  // Send FSM next state; the pop decision doubles as the next serial_send.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((fifo_count != '0) && !serial_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SENT;
        end
      end
      ST_SENT: begin
        if (serial_busy)
          w_state_nxt = ST_BUSY;
        else if (r_to_cnt == c_TW'(ACK_TIMEOUT - 1))
          w_state_nxt = ST_IDLE;  // no acknowledge: word is abandoned
      end
      ST_BUSY: begin
        if (!serial_busy) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge hash_clk) begin
    if (w_grant_any) r_mem[r_wr_ptr] <= w_pend_nonce[w_grant_idx];
  end

  always_ff @(posedge hash_clk or negedge reset_in) begin
    if (!reset_in) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      fifo_count     <= '0;
      r_rr_ptr       <= '0;
      overflow_count <= '0;
      r_state        <= ST_IDLE;
      r_to_cnt       <= '0;
      serial_send    <= 1'b0;
      golden_nonce   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      serial_send <= w_pop;

      if (w_grant_any) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_grant_idx == c_PW'(NUM_HASHERS - 1)) r_rr_ptr <= '0;
        else                                       r_rr_ptr <= w_grant_idx + 1'b1;
      end

      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        golden_nonce <= r_mem[r_rd_ptr];
      end

      if (w_grant_any && !w_pop)      fifo_count <= fifo_count + 1'b1;
      else if (!w_grant_any && w_pop) fifo_count <= fifo_count - 1'b1;

      if (clear_overflow)      overflow_count <= OVF_W'(w_drop_cnt);
      else if (w_ovf_sum[OVF_W]) overflow_count <= '1;
      else                     overflow_count <= w_ovf_sum[OVF_W-1:0];

      if (r_state != ST_SENT)  r_to_cnt <= '0;
      else if (!serial_busy)   r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
